// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive-side drain controller.
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;
  localparam int CNT_BITS_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CAPTURE,
    PRESENT,
    FL_POP,
    FL_GAP,
    FL_DONE
  } drain_state_t;

endpackage

// File: rtl/uart_rx_drain_ctrl_wrap_counter.sv
// Free-running event counter with enable and synchronous clear.
// Wraps modulo 2^W.
module wrap_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Clr,
  input  logic         En,
  output logic [W-1:0] Cnt
);

  always_ff @(posedge Clk) begin
    if (Clr) begin
      Cnt <= '0;
    end else if (En) begin
      Cnt <= Cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_drain_ctrl.sv
// Pops bytes from the UART receive FIFO and hands them to the host; also runs
// flushes that discard everything buffered while FIFO writes are inhibited.
//
// Host handshake: Host_Valid rises with Host_Data already stable, and both
// stay unchanged until the cycle Host_Valid && Host_Ready is sampled high;
// the byte is transferred on that clock edge and Host_Valid drops after it.
module uart_rx_drain_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_BITS   = CNT_BITS_DEF
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 FIFO_Empty,
  input  logic                 FIFO_Overflow,
  input  logic [DATA_BITS-1:0] FIFO_Data,
  output logic                 Read_Done,
  output logic                 Write_Inhibit,
  output logic [DATA_BITS-1:0] Host_Data,
  output logic                 Host_Valid,
  input  logic                 Host_Ready,
  input  logic                 Flush_Req,
  output logic                 Flush_Busy,
  output logic                 Ovf_Sticky,
  input  logic                 Ovf_Clr,
  output logic [CNT_BITS-1:0]  Deliv_Cnt,
  output logic [CNT_BITS-1:0]  Drop_Cnt,
  output drain_state_t         Dbg_State
);

  localparam int POP_W = $clog2(FIFO_DEPTH + 1);

  drain_state_t         state, state_nxt;
  logic                 flush_pend;
  logic                 fl_skip;
  logic [POP_W-1:0]     fl_pops;
  logic [DATA_BITS-1:0] host_data_q;
  logic                 ovf_q;

  logic read_done, host_valid, inhibit;
  logic deliv_inc, drop_inc, start_flush;

  always_comb begin
    state_nxt   = state;
    read_done   = 1'b0;
    host_valid  = 1'b0;
    inhibit     = 1'b0;
    deliv_inc   = 1'b0;
    drop_inc    = 1'b0;
    start_flush = 1'b0;
    case (state)
      IDLE: begin
        if (Flush_Req || flush_pend) begin
          state_nxt   = FL_POP;
          start_flush = 1'b1;
        end else if (!FIFO_Empty) begin
          state_nxt = POP;
        end
      end
      POP: begin
        read_done = 1'b1;
        state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = PRESENT;
      PRESENT: begin
        host_valid = 1'b1;
        if (Host_Ready) begin
          deliv_inc = 1'b1;
          // A flush requested while this byte was in flight starts right after it is taken.
          if (flush_pend || Flush_Req) begin
            state_nxt   = FL_POP;
            start_flush = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      FL_POP: begin
        read_done = 1'b1;
        inhibit   = 1'b1;
        state_nxt = FL_GAP;
      end
      FL_GAP: begin
        inhibit  = 1'b1;
        drop_inc = !fl_skip;
        if (FIFO_Empty || (fl_pops == POP_W'(FIFO_DEPTH))) begin
          state_nxt = FL_DONE;
        end else begin
          state_nxt = FL_POP;
        end
      end
      FL_DONE: begin
        inhibit   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      flush_pend  <= 1'b0;
      fl_skip     <= 1'b0;
      fl_pops     <= '0;
      host_data_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state <= state_nxt;

      if (start_flush) begin
        flush_pend <= 1'b0;
      end else if (Flush_Req && (state == POP || state == CAPTURE || state == PRESENT)) begin
        flush_pend <= 1'b1;
      end

      // The first pop of a flush entered on an empty FIFO discards nothing.
      if (start_flush) begin
        fl_skip <= FIFO_Empty;
      end else if (state == FL_GAP) begin
        fl_skip <= 1'b0;
      end

      if (start_flush) begin
        fl_pops <= '0;
      end else if (state == FL_POP) begin
        fl_pops <= fl_pops + POP_W'(1);
      end

      if (state == CAPTURE) begin
        host_data_q <= FIFO_Data;
      end

      if (FIFO_Overflow) begin
        ovf_q <= 1'b1;
      end else if (Ovf_Clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  wrap_counter #(.W(CNT_BITS)) u_deliv_cnt (
    .Clk (Clk),
    .Clr (Rst),
    .En  (deliv_inc),
    .Cnt (Deliv_Cnt)
  );

  wrap_counter #(.W(CNT_BITS)) u_drop_cnt (
    .Clk (Clk),
    .Clr (Rst),
    .En  (drop_inc),
    .Cnt (Drop_Cnt)
  );

  assign Read_Done     = read_done;
  assign Write_Inhibit = inhibit;
  assign Flush_Busy    = inhibit;
  assign Host_Valid    = host_valid;
  assign Host_Data     = host_data_q;
  assign Ovf_Sticky    = ovf_q;
  assign Dbg_State     = state;

endmodule

// File: tb/tb_uart_rx_drain_ctrl.sv
// Bench for uart_rx_drain_ctrl: behavioural FIFO model, directed scenarios,
// and a scoreboard monitor that checks every byte the host accepts.
module tb_uart_rx_drain_ctrl;
  import uart_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        FIFO_Overflow = 1'b0;
  logic        Host_Ready = 1'b0;
  logic        Flush_Req = 1'b0;
  logic        Ovf_Clr = 1'b0;
  logic        Read_Done, Write_Inhibit, Host_Valid, Flush_Busy, Ovf_Sticky;
  logic [7:0]  Host_Data;
  logic [15:0] Deliv_Cnt, Drop_Cnt;
  drain_state_t Dbg_State;

  // FIFO model
  logic [7:0] fifo_q[$];
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       rd_q = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int wi_cnt = 0;
  int adj_err = 0;
  logic [7:0] exp_q[$];

  uart_rx_drain_ctrl dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .FIFO_Empty    (fifo_empty),
    .FIFO_Overflow (FIFO_Overflow),
    .FIFO_Data     (fifo_dout),
    .Read_Done     (Read_Done),
    .Write_Inhibit (Write_Inhibit),
    .Host_Data     (Host_Data),
    .Host_Valid    (Host_Valid),
    .Host_Ready    (Host_Ready),
    .Flush_Req     (Flush_Req),
    .Flush_Busy    (Flush_Busy),
    .Ovf_Sticky    (Ovf_Sticky),
    .Ovf_Clr       (Ovf_Clr),
    .Deliv_Cnt     (Deliv_Cnt),
    .Drop_Cnt      (Drop_Cnt),
    .Dbg_State     (Dbg_State)
  );

  // Clock / reset
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // FIFO pops on the rising edge of Read_Done; flags lag by one cycle.
  always @(posedge Clk) begin
    if (wr_en && !Write_Inhibit && fifo_q.size() < 4) fifo_q.push_back(wr_data);
    if (Read_Done && !rd_q && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
    rd_q <= Read_Done;
    fifo_empty <= (fifo_q.size() == 0);
  end

  always @(posedge Clk) begin
    if (Read_Done === 1'b1) rd_cnt++;
    if (Read_Done === 1'b1 && rd_q === 1'b1) adj_err++;
    if (Write_Inhibit === 1'b1) wi_cnt++;
  end

  // Scoreboard monitor
  always @(negedge Clk) begin
    if (!Rst && Host_Valid === 1'b1 && Host_Ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_byte: got %02h, expected none", Host_Data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (Host_Data !== e) begin
          failures++;
          $display("FAIL host_byte: got %02h, expected %02h", Host_Data, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_data = b;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_state(input drain_state_t s, input string name);
    int n;
    n = 0;
    while (Dbg_State !== s && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout waiting for state %0d, at %0d", name, s, Dbg_State);
    end
  endtask

  task automatic wait_deliv(input logic [15:0] v, input string name);
    int n;
    n = 0;
    while (Deliv_Cnt !== v && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout, Deliv_Cnt %0h expected %0h", name, Deliv_Cnt, v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read_done"}, 32'(Read_Done), 0);
    chk({tag, "_inhibit"},   32'(Write_Inhibit), 0);
    chk({tag, "_busy"},      32'(Flush_Busy), 0);
    chk({tag, "_valid"},     32'(Host_Valid), 0);
    chk({tag, "_data"},      32'(Host_Data), 0);
    chk({tag, "_ovf"},       32'(Ovf_Sticky), 0);
    chk({tag, "_deliv"},     32'(Deliv_Cnt), 0);
    chk({tag, "_drop"},      32'(Drop_Cnt), 0);
    chk({tag, "_state"},     32'(Dbg_State), 32'(IDLE));
  endtask

  int rd0, wi0, bad;

  initial begin
    // Reset state
    Rst = 1'b1;
    tick(); tick();
    chk_all_zero("reset");

    // Flush of a full FIFO: preload under reset, then request in the first IDLE cycle.
    push(8'hD0); push(8'hD1); push(8'hD2); push(8'hD3);
    rd0 = rd_cnt; wi0 = wi_cnt;
    Rst = 1'b0;
    Flush_Req = 1'b1;
    tick();
    Flush_Req = 1'b0;
    chk("flush_enter", 32'(Dbg_State), 32'(FL_POP));
    wait_state(IDLE, "flush_done");
    chk("flush_inhibit_cycles", 32'(wi_cnt - wi0), 9);
    chk("flush_pops", 32'(rd_cnt - rd0), 4);
    chk("flush_drop", 32'(Drop_Cnt), 4);
    chk("flush_fifo_empty", 32'(fifo_empty), 1);

    // Flush on an already empty FIFO
    rd0 = rd_cnt; wi0 = wi_cnt;
    Flush_Req = 1'b1;
    tick();
    Flush_Req = 1'b0;
    wait_state(IDLE, "eflush_done");
    chk("eflush_inhibit_cycles", 32'(wi_cnt - wi0), 3);
    chk("eflush_pops", 32'(rd_cnt - rd0), 1);
    chk("eflush_drop", 32'(Drop_Cnt), 4);

    // Single byte, host always ready
    Host_Ready = 1'b1;
    rd0 = rd_cnt;
    exp_q.push_back(8'hA5);
    push(8'hA5);
    tick(); tick(); tick();
    chk("single_valid_latency", 32'(Host_Valid), 1);
    chk("single_data", 32'(Host_Data), 32'h A5);
    tick();
    chk("single_deliv", 32'(Deliv_Cnt), 1);
    chk("single_state", 32'(Dbg_State), 32'(IDLE));
    chk("single_pops", 32'(rd_cnt - rd0), 1);

    // Backpressure
    Host_Ready = 1'b0;
    rd0 = rd_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    push(8'h11);
    push(8'h22);
    wait_state(PRESENT, "bp_present");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Host_Valid !== 1'b1 || Host_Data !== 8'h11) bad++;
    end
    chk("bp_stable_cycles_bad", 32'(bad), 0);
    chk("bp_single_pop", 32'(rd_cnt - rd0), 1);
    Host_Ready = 1'b1;
    wait_deliv(16'd3, "bp_deliv");
    wait_state(IDLE, "bp_idle");
    chk("bp_deliv", 32'(Deliv_Cnt), 3);
    chk("bp_pops", 32'(rd_cnt - rd0), 2);

    // Flush requested while a byte is presented
    Host_Ready = 1'b0;
    exp_q.push_back(8'h33);
    push(8'h33);
    wait_state(PRESENT, "fp_present");
    push(8'h44);
    push(8'h55);
    Flush_Req = 1'b1;
    tick();
    Flush_Req = 1'b0;
    tick(); tick(); tick();
    chk("fp_hold_state", 32'(Dbg_State), 32'(PRESENT));
    chk("fp_hold_data", 32'(Host_Data), 32'h33);
    Host_Ready = 1'b1;
    wait_deliv(16'd4, "fp_deliv");
    chk("fp_flush_starts", 32'(Dbg_State), 32'(FL_POP));
    wait_state(IDLE, "fp_idle");
    chk("fp_drop", 32'(Drop_Cnt), 6);
    chk("fp_fifo_empty", 32'(fifo_empty), 1);

    // Overflow sticky flag
    FIFO_Overflow = 1'b1;
    tick();
    FIFO_Overflow = 1'b0;
    tick(); tick();
    chk("ovf_set", 32'(Ovf_Sticky), 1);
    FIFO_Overflow = 1'b1;
    Ovf_Clr = 1'b1;
    tick();
    FIFO_Overflow = 1'b0;
    Ovf_Clr = 1'b0;
    chk("ovf_set_wins", 32'(Ovf_Sticky), 1);
    Ovf_Clr = 1'b1;
    tick();
    Ovf_Clr = 1'b0;
    chk("ovf_clear", 32'(Ovf_Sticky), 0);

    // Reset in the middle of a flush
    Flush_Req = 1'b1;
    tick();
    Flush_Req = 1'b0;
    wait_state(FL_GAP, "rst_gap");
    chk("rst_pre_inhibit", 32'(Write_Inhibit), 1);
    Rst = 1'b1;
    tick();
    chk_all_zero("rst_mid");
    Rst = 1'b0;
    tick(); tick();

    chk("no_adjacent_read_done", 32'(adj_err), 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_drain_ctrl.md
# uart_rx_drain_ctrl

Sequencing controller that sits between the UART receive FIFO and the host-side consumer. It pops bytes from the FIFO with a one-cycle `Read_Done` strobe, captures the FIFO's `Data_Out`, and presents each byte on a valid/ready handshake. It also runs a flush command that inhibits FIFO writes and discards all buffered bytes. Overflow is reported through a sticky flag, and delivered and discarded bytes are counted.

## Interface
- `DATA_BITS`, 8: width of a received byte.
- `FIFO_DEPTH`, 4: depth of the attached FIFO; bounds the flush pop count.
- `CNT_BITS`, 16: width of the delivered and dropped counters.

- `Clk`  in  1  system clock; all inputs are synchronous to it.
- `Rst`  in  1  synchronous, active-high reset.
- `FIFO_Empty`  in  1  FIFO empty flag.
- `FIFO_Overflow`  in  1  FIFO overflow flag.
- `FIFO_Data`  in  DATA_BITS  FIFO `Data_Out`; valid from the second cycle after the `Read_Done` rise.
- `Read_Done`  out  1  pop strobe to the FIFO.
- `Write_Inhibit`  out  1  drives the FIFO `BIST_Mode` input; blocks FIFO writes.
- `Host_Data`  out  DATA_BITS  byte presented to the host.
- `Host_Valid`  out  1  `Host_Data` is valid.
- `Host_Ready`  in  1  host accepts the byte.
- `Flush_Req`  in  1  single-cycle pulse that requests a flush.
- `Flush_Busy`  out  1  flush in progress.
- `Ovf_Sticky`  out  1  latched overflow flag.
- `Ovf_Clr`  in  1  clears `Ovf_Sticky`.
- `Deliv_Cnt`  out  CNT_BITS  number of bytes accepted by the host.
- `Drop_Cnt`  out  CNT_BITS  number of bytes discarded by flushes.

## Operation
- **Reset values:** state IDLE; all outputs 0.
- **FSM states and transitions:**
  - IDLE:
    - `Flush_Req` → FL_POP.
    - Otherwise, `!FIFO_Empty` → POP.
  - POP: `Read_Done`=1 for exactly one cycle → CAPTURE.
  - CAPTURE: `Read_Done`=0. Latch `FIFO_Data` into `Host_Data` → PRESENT.
  - PRESENT: `Host_Valid`=1.
    - On `Host_Valid && Host_Ready`: `Deliv_Cnt`++, then → IDLE.
    - `Host_Data` and `Host_Valid` hold stable until accepted.
- **Flush states:**
  - FL_POP: `Read_Done`=1 → FL_GAP.
  - FL_GAP: `Read_Done`=0; `Drop_Cnt`++.
    - If `FIFO_Empty` is sampled in FL_GAP, or `FIFO_DEPTH` pops are done → FL_DONE.
    - Else → FL_POP.
  - FL_DONE: one cycle → IDLE.
  - `Write_Inhibit`=1 and `Flush_Busy`=1 in FL_POP, FL_GAP and FL_DONE.
- **`Flush_Req` arriving in other states:**
  - In POP, CAPTURE or PRESENT, `Flush_Req` is latched as pending.
  - The flush starts in the cycle after the current byte is accepted.
  - An in-flight byte is never dropped.
- **Flush when the FIFO is already empty:** FL_POP is still entered once (a `Read_Done` pop on an empty FIFO has no effect). `Drop_Cnt` is not incremented if `FIFO_Empty` was 1 on entry.
- **`Ovf_Sticky`:**
  - Set on any cycle with `FIFO_Overflow`=1.
  - `Ovf_Clr` clears it.
  - When both occur in the same cycle, set wins.
- **Counters:** wrap modulo 2^`CNT_BITS`. No saturation.
- **`Read_Done` rule:** never high on two consecutive cycles, so the FIFO sees a clean rising edge every time.

## Timing
- Latency from `FIFO_Empty` falling (sampled in IDLE) to `Host_Valid`: 3 cycles (IDLE → POP → CAPTURE → PRESENT).
- Minimum of 4 cycles per delivered byte with `Host_Ready` held high.
- The FIFO flags lag a pop. IDLE re-samples `FIFO_Empty` no earlier than 2 cycles after `Read_Done`, and FL_GAP samples it 1 cycle after.
- A flush of N bytes takes 2N+1 cycles from FL_POP entry to return to IDLE.
- `Rst` asserted mid-operation:
  - Returns to IDLE on the next edge and drops `Write_Inhibit` and `Host_Valid`.
  - Pending flush and both counters are cleared.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum `drain_state_t`;
  - the default `DATA_BITS`;
  - the default `CNT_BITS`.
- Natural sub-module: `wrap_counter`, a parameterised counter with enable and synchronous clear, instantiated twice (`Deliv_Cnt`, `Drop_Cnt`).

## Test plan
- **Single byte:** push 0xA5 into the FIFO with `Host_Ready`=1 → one `Read_Done` pulse, `Host_Data`=0xA5 three cycles later, `Deliv_Cnt`=1, FSM back in IDLE.
- **Backpressure:** push 0x11 and 0x22, hold `Host_Ready`=0 for 10 cycles → `Host_Valid`=1 and `Host_Data`=0x11 stable throughout, no second `Read_Done` until acceptance, then 0x22 is delivered.
- **Flush:** fill the FIFO with 4 bytes, pulse `Flush_Req` in IDLE → 4 non-adjacent `Read_Done` pulses, `Write_Inhibit` high for 9 cycles, `Drop_Cnt`=4, `FIFO_Empty`=1 after.
- **Flush during PRESENT:** `Flush_Req` while 0x33 is presented → 0x33 is still delivered (`Deliv_Cnt`+1), then the flush runs over the remaining bytes.
- **Overflow:** drive `FIFO_Overflow`=1 for 1 cycle → `Ovf_Sticky` stays 1. Assert `Ovf_Clr` and `FIFO_Overflow` together → flag remains 1. Assert `Ovf_Clr` alone → flag is 0.
- **Reset mid-flush:** assert `Rst` in FL_GAP → next cycle all outputs are 0 and the FSM is in IDLE.
